// File: rtl/ctrl_pc_sequencer.sv
// Fetch-side program counter sequencer: stall/halt holds, EX-stage redirects,
// a hardware return-address stack and a fixed-length flush after each redirect.
module ctrl_pc_sequencer #(
  parameter int PROG_CTR_WID = 10,
  parameter int RS_DEPTH     = 4,
  parameter int FLUSH_CYC    = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stall_ID,
  input  logic                          halt_ID,
  input  logic                          resume,
  input  logic                          branch_taken_EX,
  input  logic                          call_EX,
  input  logic                          ret_EX,
  input  logic [PROG_CTR_WID-1:0]       nxt_prog_ctr_EX,
  input  logic [PROG_CTR_WID-1:0]       ret_addr_EX,
  output logic [PROG_CTR_WID-1:0]       prog_ctr,
  output logic                          fetch_en,
  output logic                          flush_pipe,
  output logic                          halted,
  output logic [$clog2(RS_DEPTH+1)-1:0] rs_count,
  output logic                          rs_overflow,
  output logic                          rs_underflow
);

  localparam int CW = $clog2(RS_DEPTH + 1);
  localparam int AW = $clog2(RS_DEPTH);
  localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [PROG_CTR_WID-1:0] PC_ONE = PROG_CTR_WID'(1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FLUSH,
    ST_HALT
  } state_t;

  state_t                  state_reg, state_next;
  logic [PROG_CTR_WID-1:0] pc_reg, pc_next;
  logic                    fetch_reg, fetch_next;
  logic                    flush_reg, flush_next;
  logic                    halted_reg, halted_next;
  logic [FW-1:0]           cnt_reg, cnt_next;
  logic [CW-1:0]           count_reg, count_next;
  logic                    ovf_reg, ovf_next;
  logic                    unf_reg, unf_next;

  logic [PROG_CTR_WID-1:0] stack_reg [RS_DEPTH];
  logic                    push_en;
  logic [AW-1:0]           push_idx;
  logic [AW-1:0]           top_idx;
  logic [PROG_CTR_WID-1:0] top_addr;

  // Entry count is a power of two, so a full stack's count truncates to index 0.
  assign push_idx = AW'(count_reg);
  assign top_idx  = AW'(count_reg) - AW'(1);
  assign top_addr = stack_reg[top_idx];

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    fetch_next  = fetch_reg;
    flush_next  = flush_reg;
    halted_next = halted_reg;
    cnt_next    = cnt_reg;
    count_next  = count_reg;
    ovf_next    = ovf_reg;
    unf_next    = unf_reg;
    push_en     = 1'b0;

    case (state_reg)
      ST_RUN: begin
        if (ret_EX || call_EX || branch_taken_EX) begin
          state_next = ST_FLUSH;
          flush_next = 1'b1;
          fetch_next = 1'b1;
          cnt_next   = FW'(FLUSH_CYC - 1);
          pc_next    = nxt_prog_ctr_EX;
          if (ret_EX) begin
            if (count_reg != '0) begin
              pc_next    = top_addr;
              count_next = count_reg - CW'(1);
            end else begin
              // Returning with nothing to return to: park at 0 and stop.
              pc_next     = '0;
              unf_next    = 1'b1;
              state_next  = ST_HALT;
              flush_next  = 1'b0;
              fetch_next  = 1'b0;
              halted_next = 1'b1;
            end
          end else if (call_EX) begin
            if (count_reg < CW'(RS_DEPTH)) begin
              push_en    = 1'b1;
              count_next = count_reg + CW'(1);
            end else begin
              ovf_next = 1'b1;
            end
          end
        end else if (halt_ID) begin
          state_next  = ST_HALT;
          fetch_next  = 1'b0;
          halted_next = 1'b1;
        end else if (stall_ID) begin
          fetch_next = 1'b0;
        end else begin
          // Advance only past an address that was actually fetched.
          if (fetch_reg) begin
            pc_next = pc_reg + PC_ONE;
          end
          fetch_next = 1'b1;
        end
      end

      ST_FLUSH: begin
        pc_next    = pc_reg + PC_ONE;
        fetch_next = 1'b1;
        if (cnt_reg == '0) begin
          state_next = ST_RUN;
          flush_next = 1'b0;
        end else begin
          cnt_next = cnt_reg - FW'(1);
        end
      end

      ST_HALT: begin
        if (resume) begin
          state_next  = ST_RUN;
          fetch_next  = 1'b1;
          halted_next = 1'b0;
        end
      end

      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= ST_RUN;
      pc_reg     <= '0;
      fetch_reg  <= 1'b0;
      flush_reg  <= 1'b0;
      halted_reg <= 1'b0;
      cnt_reg    <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
      unf_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      fetch_reg  <= fetch_next;
      flush_reg  <= flush_next;
      halted_reg <= halted_next;
      cnt_reg    <= cnt_next;
      count_reg  <= count_next;
      ovf_reg    <= ovf_next;
      unf_reg    <= unf_next;
    end
  end

  // Stack contents are never cleared; only the count defines validity.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_reg[push_idx] <= ret_addr_EX;
    end
  end

  assign prog_ctr     = pc_reg;
  assign fetch_en     = fetch_reg;
  assign flush_pipe   = flush_reg;
  assign halted       = halted_reg;
  assign rs_count     = count_reg;
  assign rs_overflow  = ovf_reg;
  assign rs_underflow = unf_reg;

endmodule

// File: tb/tb_ctrl_pc_sequencer.sv
// Scoreboard bench for ctrl_pc_sequencer: directed scenarios plus random traffic,
// checked cycle by cycle against a queue-based behavioural model.
module tb_ctrl_pc_sequencer;

  localparam int FLUSH_CYC = 2;
  localparam int RS_DEPTH  = 4;

  logic       clk;
  logic       reset;
  logic       stall_ID, halt_ID, resume, branch_taken_EX, call_EX, ret_EX;
  logic [9:0] nxt_prog_ctr_EX, ret_addr_EX;
  logic [9:0] prog_ctr;
  logic       fetch_en, flush_pipe, halted, rs_overflow, rs_underflow;
  logic [2:0] rs_count;

  ctrl_pc_sequencer #(
    .PROG_CTR_WID(10),
    .RS_DEPTH(RS_DEPTH),
    .FLUSH_CYC(FLUSH_CYC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .stall_ID(stall_ID),
    .halt_ID(halt_ID),
    .resume(resume),
    .branch_taken_EX(branch_taken_EX),
    .call_EX(call_EX),
    .ret_EX(ret_EX),
    .nxt_prog_ctr_EX(nxt_prog_ctr_EX),
    .ret_addr_EX(ret_addr_EX),
    .prog_ctr(prog_ctr),
    .fetch_en(fetch_en),
    .flush_pipe(flush_pipe),
    .halted(halted),
    .rs_count(rs_count),
    .rs_overflow(rs_overflow),
    .rs_underflow(rs_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] pc;
    logic       fe;
    logic       fl;
    logic       hl;
    logic [2:0] cnt;
    logic       ovf;
    logic       unf;
  } obs_t;

  obs_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Behavioural model state
  logic [9:0] m_pc;
  bit         m_fetch;
  bit         m_halted;
  int         m_flush_left;
  logic [9:0] m_stack[$];
  bit         m_ovf, m_unf;

  task automatic model_reset();
    m_pc = '0; m_fetch = 0; m_halted = 0; m_flush_left = 0;
    m_stack.delete(); m_ovf = 0; m_unf = 0;
  endtask

  task automatic model_redirect(input logic [9:0] target);
    m_pc = target;
    m_fetch = 1;
    m_flush_left = FLUSH_CYC;
  endtask

  task automatic model_step(input bit st, input bit hl, input bit rs, input bit br,
                            input bit ca, input bit rt, input logic [9:0] tgt,
                            input logic [9:0] ra);
    if (m_halted) begin
      if (rs) begin
        m_halted = 0;
        m_fetch = 1;
      end
    end else if (m_flush_left > 0) begin
      m_pc = m_pc + 10'd1;
      m_fetch = 1;
      m_flush_left--;
    end else if (rt) begin
      if (m_stack.size() > 0) begin
        model_redirect(m_stack.pop_back());
      end else begin
        m_pc = '0; m_unf = 1; m_halted = 1; m_fetch = 0;
      end
    end else if (ca) begin
      if (m_stack.size() < RS_DEPTH) m_stack.push_back(ra);
      else m_ovf = 1;
      model_redirect(tgt);
    end else if (br) begin
      model_redirect(tgt);
    end else if (hl) begin
      m_halted = 1; m_fetch = 0;
    end else if (st) begin
      m_fetch = 0;
    end else begin
      if (m_fetch) m_pc = m_pc + 10'd1;
      m_fetch = 1;
    end
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.pc  = m_pc;
    o.fe  = m_fetch;
    o.fl  = (m_flush_left > 0);
    o.hl  = m_halted;
    o.cnt = 3'(m_stack.size());
    o.ovf = m_ovf;
    o.unf = m_unf;
    return o;
  endfunction

  // Drive one cycle's inputs (caller is at a negedge) and queue the expected result.
  task automatic apply(input bit st, input bit hl, input bit rs, input bit br,
                       input bit ca, input bit rt, input logic [9:0] tgt,
                       input logic [9:0] ra);
    stall_ID = st; halt_ID = hl; resume = rs; branch_taken_EX = br;
    call_EX = ca; ret_EX = rt; nxt_prog_ctr_EX = tgt; ret_addr_EX = ra;
    model_step(st, hl, rs, br, ca, rt, tgt, ra);
    sb_q.push_back(model_obs());
  endtask

  task automatic cycle(input bit st, input bit hl, input bit rs, input bit br,
                       input bit ca, input bit rt, input logic [9:0] tgt,
                       input logic [9:0] ra);
    @(negedge clk);
    apply(st, hl, rs, br, ca, rt, tgt, ra);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 10'h000, 10'h000);
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end else begin
      $display("check %s: %0h ok", name, got);
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: one expected observation per clock edge following a drive.
  initial begin
    obs_t e, g;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        g = '{pc: prog_ctr, fe: fetch_en, fl: flush_pipe, hl: halted,
              cnt: rs_count, ovf: rs_overflow, unf: rs_underflow};
        cyc++;
        total++;
        if (g !== e) begin
          bad++;
          $display("FAIL sb cyc=%0d got pc=%h fe=%b fl=%b hl=%b cnt=%0d ovf=%b unf=%b expected pc=%h fe=%b fl=%b hl=%b cnt=%0d ovf=%b unf=%b",
                   cyc, g.pc, g.fe, g.fl, g.hl, g.cnt, g.ovf, g.unf,
                   e.pc, e.fe, e.fl, e.hl, e.cnt, e.ovf, e.unf);
        end else begin
          $display("cyc=%0d pc=%h fe=%b fl=%b hl=%b cnt=%0d ovf=%b unf=%b",
                   cyc, g.pc, g.fe, g.fl, g.hl, g.cnt, g.ovf, g.unf);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    stall_ID = 0; halt_ID = 0; resume = 0; branch_taken_EX = 0;
    call_EX = 0; ret_EX = 0; nxt_prog_ctr_EX = '0; ret_addr_EX = '0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", 16'(prog_ctr), 16'h0);
    chk("rst_fetch", 16'(fetch_en), 16'h0);
    chk("rst_flush", 16'(flush_pipe), 16'h0);
    chk("rst_halted", 16'(halted), 16'h0);
    chk("rst_count", 16'(rs_count), 16'h0);

    // Count up from reset: 0,1,2,3
    @(negedge clk);
    reset = 1'b0;
    apply(0, 0, 0, 0, 0, 0, 10'h000, 10'h000);
    idle(3);
    settle();
    chk("count_pc3", 16'(prog_ctr), 16'h3);
    chk("count_fetch", 16'(fetch_en), 16'h1);
    idle(2);

    // Asynchronous reset between clock edges
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("async_pc", 16'(prog_ctr), 16'h0);
    chk("async_fetch", 16'(fetch_en), 16'h0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    apply(0, 0, 0, 0, 0, 0, 10'h000, 10'h000);
    idle(5);

    // Branch with simultaneous stall at pc=5; branch during flush ignored
    cycle(1, 0, 0, 1, 0, 0, 10'h040, 10'h000);
    settle();
    chk("br_pc", 16'(prog_ctr), 16'h040);
    chk("br_flush", 16'(flush_pipe), 16'h1);
    cycle(0, 0, 0, 1, 0, 0, 10'h200, 10'h000);
    idle(1);
    settle();
    chk("br_after_pc", 16'(prog_ctr), 16'h042);
    chk("br_after_flush", 16'(flush_pipe), 16'h0);
    idle(2);

    // Call then return
    cycle(0, 0, 0, 0, 1, 0, 10'h100, 10'h011);
    settle();
    chk("call_pc", 16'(prog_ctr), 16'h100);
    chk("call_cnt", 16'(rs_count), 16'h1);
    idle(3);
    cycle(0, 0, 0, 0, 0, 1, 10'h000, 10'h000);
    settle();
    chk("ret_pc", 16'(prog_ctr), 16'h011);
    chk("ret_cnt", 16'(rs_count), 16'h0);
    chk("ret_flush", 16'(flush_pipe), 16'h1);
    idle(3);

    // Five calls into a four-entry stack
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 0, 1, 0, 10'(10'h080 + i * 16), 10'(10'h300 + i));
      if (i == 4) begin
        settle();
        chk("ovf_pc", 16'(prog_ctr), 16'h0C0);
        chk("ovf_cnt", 16'(rs_count), 16'h4);
        chk("ovf_flag", 16'(rs_overflow), 16'h1);
      end
      idle(3);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 0, 0, 1, 10'h000, 10'h000);
      if (i == 0) begin
        settle();
        chk("pop_top", 16'(prog_ctr), 16'h303);
      end
      idle(3);
    end
    cycle(0, 0, 0, 0, 0, 1, 10'h000, 10'h000);
    settle();
    chk("unf_pc", 16'(prog_ctr), 16'h0);
    chk("unf_flag", 16'(rs_underflow), 16'h1);
    chk("unf_halted", 16'(halted), 16'h1);
    cycle(0, 0, 1, 0, 0, 0, 10'h000, 10'h000);
    idle(2);

    // Halt at 0x020 with noise on ignored inputs, then resume
    cycle(0, 0, 0, 1, 0, 0, 10'h01E, 10'h000);
    idle(2);
    cycle(0, 1, 0, 0, 0, 0, 10'h000, 10'h000);
    settle();
    chk("halt_pc", 16'(prog_ctr), 16'h020);
    chk("halt_fetch", 16'(fetch_en), 16'h0);
    chk("halt_flag", 16'(halted), 16'h1);
    for (int i = 0; i < 10; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)),
            10'($urandom_range(0, 1023)));
    end
    settle();
    chk("halt_hold_pc", 16'(prog_ctr), 16'h020);
    cycle(0, 0, 1, 0, 0, 0, 10'h000, 10'h000);
    settle();
    chk("resume_fetch", 16'(fetch_en), 16'h1);
    chk("resume_pc", 16'(prog_ctr), 16'h020);
    idle(1);
    settle();
    chk("resume_next_pc", 16'(prog_ctr), 16'h021);

    // Wrap from all-ones
    cycle(0, 0, 0, 1, 0, 0, 10'h3FF, 10'h000);
    settle();
    chk("wrap_target", 16'(prog_ctr), 16'h3FF);
    idle(1);
    settle();
    chk("wrap_zero", 16'(prog_ctr), 16'h000);
    idle(2);

    // Simultaneous ret and call: only the return acts
    cycle(0, 0, 0, 0, 1, 0, 10'h150, 10'h055);
    idle(3);
    cycle(0, 0, 0, 1, 1, 1, 10'h2AA, 10'h123);
    settle();
    chk("retcall_pc", 16'(prog_ctr), 16'h055);
    chk("retcall_cnt", 16'(rs_count), 16'h0);
    idle(3);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 99) < 20), 1'($urandom_range(0, 99) < 3),
            1'($urandom_range(0, 99) < 15), 1'($urandom_range(0, 99) < 7),
            1'($urandom_range(0, 99) < 7), 1'($urandom_range(0, 99) < 5),
            10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)));
    end
    idle(1);

    @(posedge clk);
    #3;
    chk("sb_drain", 16'(sb_q.size()), 16'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
